// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single SoC memory/peripheral bus port among NUM_REQ masters
// (instruction fetch, data load/store, VGA framebuffer fetch). One transaction
// is outstanding at a time; the bus-side request fields are registered and
// held stable until the bus accepts them.
//
// Arbitration is round-robin: the scan for a winner starts at the priority
// pointer ptr, and ptr moves to the slot after the owner once its transaction
// completes (write accepted, or read data returned).
//
// Build option:
//   MEM_ARB_FIXED_PRIORITY_EN  when defined, ptr is ignored and never moves;
//                              the lowest-index requester always wins.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   req, req_we           per-requester request / write enable
//   req_addr/wdata/wmask  flattened per-requester fields, requester i at slice i
//   gnt                   one-hot accept pulse, combinational in the accept cycle
//   rvalid, rdata         one-hot read-valid pulse and shared read data
//   mem_req/we/addr/      registered bus request towards the bus decoder
//   mem_wdata/wmask
//   mem_ready             bus accepts mem_req this cycle
//   mem_rvalid, mem_rdata bus read return
//   busy                  high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wmask,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic [DATA_WIDTH/8-1:0]          mem_wmask,
  input  logic                             mem_ready,
  input  logic                             mem_rvalid,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             busy
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_d;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   owner_next;
  logic [IDX_W-1:0]   win;
  logic               found;
  logic [IDX_W:0]     cand;
  logic [IDX_W-1:0]   cand_idx;
  logic               accept;

  logic               sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MASK_W-1:0]  sel_wmask;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      oh[k] = (idx == IDX_W'(k));
    end
    return oh;
  endfunction

  // Slot after the owner, wrapping at NUM_REQ (NUM_REQ need not be a power
  // of two, so a plain increment is not enough).
  assign owner_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Winner selection: first set request bit scanning from the start slot.
  // The candidate is kept one bit wider so ptr+k can exceed NUM_REQ-1
  // before the wrap subtraction.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      cand = (IDX_W+1)'(k);
`else
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
`endif
      cand_idx = cand[IDX_W-1:0];
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  // Field mux for the winning requester, with constant slice bases only.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == IDX_W'(k)) begin
        sel_we    = req_we[k];
        sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_wmask = req_wmask[k*MASK_W +: MASK_W];
      end
    end
  end

  assign accept = (state == ISSUE) && mem_req && mem_ready;
  assign busy   = (state != IDLE);

  // Next-state logic; gnt is a combinational pulse in the accept cycle.
  always_comb begin
    state_d = state;
    gnt     = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          gnt     = idx_onehot(owner);
          state_d = mem_we ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Request latch / bus drive / read return. The latched fields are the
  // committed request: later changes on req_* do not reach the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      owner     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      rvalid    <= '0;
      rdata     <= '0;
    end else begin
      rvalid <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner     <= win;
            mem_req   <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wmask <= sel_wmask;
          end
        end
        ISSUE: begin
          if (accept) begin
            mem_req <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            if (mem_we) begin
              ptr <= owner_next;
            end
`endif
          end
        end
        WAIT_RD: begin
          if (mem_rvalid) begin
            rvalid <= idx_onehot(owner);
            rdata  <= mem_rdata;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            ptr    <= owner_next;
`endif
          end
        end
        default: begin
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Testbench for mem_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level model of the arbiter
// (priority pointer as an integer, winner found by modular scan).
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*MW-1:0] req_wmask;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [MW-1:0]   mem_wmask;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  logic            we_a    [N];
  logic [AW-1:0]   addr_a  [N];
  logic [DW-1:0]   wdata_a [N];
  logic [MW-1:0]   mask_a  [N];

  int errors = 0;
  int checks = 0;
  int mptr = 0;
  int cyc = 0;
  int last_gnt_cyc = 0;
  logic [DW-1:0] last_rd = '0;

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign req_we[g]              = we_a[g];
    assign req_addr[g*AW +: AW]   = addr_a[g];
    assign req_wdata[g*DW +: DW]  = wdata_a[g];
    assign req_wmask[g*MW +: MW]  = mask_a[g];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: first requesting slot scanning upward from
  // the pointer (or from 0 for fixed priority), modulo N.
  function automatic int model_winner(input logic [N-1:0] r, input int p);
    int base;
    int rm;
    int idx;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    base = 0;
    if (p < 0) base = 0;
`else
    base = p;
`endif
    rm = int'(r);
    for (int k = 0; k < N; k++) begin
      idx = (base + k) % N;
      if (((rm >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_gnt"},    64'(gnt),       64'(0));
    chk({tag, "_rvalid"}, 64'(rvalid),    64'(0));
    chk({tag, "_rdata"},  64'(rdata),     64'(0));
    chk({tag, "_mreq"},   64'(mem_req),   64'(0));
    chk({tag, "_mwe"},    64'(mem_we),    64'(0));
    chk({tag, "_maddr"},  64'(mem_addr),  64'(0));
    chk({tag, "_mwdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_mwmask"}, 64'(mem_wmask), 64'(0));
    chk({tag, "_busy"},   64'(busy),      64'(0));
  endtask

  // One complete transaction, entered at the start of an IDLE cycle.
  task automatic run_txn(input logic [N-1:0] reqv, input int wait_n, input int rv_delay,
                         input logic [DW-1:0] rd_val, input bit drop, input int gap_exp);
    int w;
    logic [IW-1:0] wi;
    logic ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [MW-1:0] em;
    w   = model_winner(reqv, mptr);
    wi  = IW'(w);
    ewe = we_a[wi];
    ea  = addr_a[wi];
    ed  = wdata_a[wi];
    em  = mask_a[wi];
    req = reqv;
    #1;
    chk("idle_gnt", 64'(gnt), 64'(0));
    step();
    chk("issue_mreq",   64'(mem_req),   64'(1));
    chk("issue_busy",   64'(busy),      64'(1));
    chk("issue_we",     64'(mem_we),    64'(ewe));
    chk("issue_addr",   64'(mem_addr),  64'(ea));
    chk("issue_wdata",  64'(mem_wdata), 64'(ed));
    chk("issue_wmask",  64'(mem_wmask), 64'(em));
    if (drop) begin
      req        = '0;
      addr_a[wi] = ~ea;
      wdata_a[wi] = ~ed;
      mask_a[wi] = ~em;
    end
    for (int i = 0; i < wait_n; i++) begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      #1;
      chk("wait_gnt", 64'(gnt), 64'(0));
      step();
      chk("hold_mreq",  64'(mem_req),   64'(1));
      chk("hold_we",    64'(mem_we),    64'(ewe));
      chk("hold_addr",  64'(mem_addr),  64'(ea));
      chk("hold_wdata", 64'(mem_wdata), 64'(ed));
      chk("hold_wmask", 64'(mem_wmask), 64'(em));
      chk("hold_rvalid", 64'(rvalid),   64'(0));
    end
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    #1;
    chk("gnt", 64'(gnt), 64'(1) << w);
    chk("gnt_addr", 64'(mem_addr), 64'(ea));
    if (gap_exp != 0) chk("gnt_gap", 64'(cyc - last_gnt_cyc), 64'(gap_exp));
    last_gnt_cyc = cyc;
    step();
    mem_ready = 1'b0;
    chk("post_gnt", 64'(gnt),     64'(0));
    chk("post_mreq", 64'(mem_req), 64'(0));
    if (ewe) begin
      chk("wr_busy",   64'(busy),   64'(0));
      chk("wr_rvalid", 64'(rvalid), 64'(0));
      chk("wr_rdata",  64'(rdata),  64'(last_rd));
    end else begin
      chk("rd_busy", 64'(busy), 64'(1));
      for (int i = 0; i < rv_delay; i++) begin
        step();
        chk("rd_wait_rvalid", 64'(rvalid), 64'(0));
        chk("rd_wait_busy",   64'(busy),   64'(1));
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rd_val;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      last_rd    = rd_val;
      chk("rvalid", 64'(rvalid), 64'(1) << w);
      chk("rdata",  64'(rdata),  64'(rd_val));
      chk("rd_done_busy", 64'(busy), 64'(0));
    end
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    mptr = (w + 1) % N;
`endif
    req = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    for (int i = 0; i < N; i++) begin
      we_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0; mask_a[i] = '0;
    end
    step();
    step();
    chk_reset_values("reset");
    rst_n = 1'b1;

    // Single read from requester 0.
    addr_a[0] = 32'h0000_0100;
    run_txn(3'b001, 0, 1, 32'hDEAD_BEEF, 1'b0, 0);

    // Bring the pointer back to 0, then all three requesting writes.
    we_a[2] = 1'b1;
    run_txn(3'b100, 0, 0, '0, 1'b0, 0);
    for (int i = 0; i < N; i++) begin
      we_a[i] = 1'b1; addr_a[i] = $urandom; wdata_a[i] = $urandom; mask_a[i] = 4'($urandom);
    end
    for (int i = 0; i < 6; i++) run_txn(3'b111, 0, 0, '0, 1'b0, (i > 0) ? 2 : 0);

    // Stalled write from requester 1.
    addr_a[1] = 32'h8000_0000; wdata_a[1] = 32'h1234_5678; mask_a[1] = 4'b0011;
    run_txn(3'b010, 3, 0, '0, 1'b0, 0);

    // Requester 2 withdraws after being latched; the next winner shows ptr.
    run_txn(3'b100, 1, 0, '0, 1'b1, 0);
    run_txn(3'b111, 0, 0, '0, 1'b0, 0);

    // Reset in the middle of a read.
    run_txn(3'b001, 0, 0, '0, 1'b0, 0);
    we_a[2] = 1'b0;
    req = 3'b100;
    step();
    req = '0;
    mem_ready = 1'b1;
    #1;
    chk("mid_gnt", 64'(gnt), 64'(3'b100));
    step();
    mem_ready = 1'b0;
    chk("mid_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    chk("midrst_rvalid", 64'(rvalid), 64'(0));
    chk("midrst_rdata",  64'(rdata),  64'(0));
    chk("midrst_busy",   64'(busy),   64'(0));
    mptr = 0;
    last_rd = '0;
    we_a[0] = 1'b1; we_a[1] = 1'b1; we_a[2] = 1'b1;
    run_txn(3'b111, 0, 0, '0, 1'b0, 0);

    // Requesters 1 and 2 held.
    for (int i = 0; i < 4; i++) run_txn(3'b110, 0, 0, '0, 1'b0, (i > 0) ? 2 : 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        we_a[i] = 1'($urandom); addr_a[i] = $urandom;
        wdata_a[i] = $urandom; mask_a[i] = 4'($urandom);
      end
      run_txn(N'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), $urandom, 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
